// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared constants and state encoding for the SPI master
package spi_defs;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CMD_W  = 8;
  localparam int ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT0   = 3'd2,
    TURN     = 3'd3,
    SHIFT1   = 3'd4,
    CS_HOLD  = 3'd5,
    DONE     = 3'd6,
    CS_IDLE  = 3'd7
  } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - loadable saturating down-counter timing every SPI phase
module spi_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Load wins; otherwise count down and park at zero so an unused timer stays quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A phase loaded with N spans N cycles; the last one is the cycle where cnt is 1.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - two-byte SPI mode-0 master for the lab memory slave
module spi_master
  import spi_defs::*;
#(
  parameter int HALF_PERIOD = 25,
  parameter int TURNAROUND  = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CMD_W-1:0]  wdata,
  output logic [CMD_W-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  localparam int MAX_PHASE = (HALF_PERIOD > TURNAROUND) ? HALF_PERIOD : TURNAROUND;
  localparam int CW        = $clog2(MAX_PHASE) + 1;
  localparam logic [CW-1:0] HP_V = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] TA_V = CW'(TURNAROUND);

  state_t           state;
  logic             rw_q;
  logic [CMD_W-1:0] wdata_q;
  logic [CMD_W-1:0] shift_out;
  logic [CMD_W-1:0] shift_in;
  logic [2:0]       bit_cnt;

  logic             tmr_load;
  logic [CW-1:0]    tmr_value;
  logic             tmr_expire;

  spi_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expire     (tmr_expire)
  );

  // Reload the timer at every phase boundary; only the end of byte 0 loads the turnaround gap.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = HP_V;
    case (state)
      IDLE: tmr_load = start;
      CS_SETUP, TURN: tmr_load = tmr_expire;
      SHIFT0: begin
        tmr_load = tmr_expire;
        if (sclk_pin && bit_cnt == 3'd7) begin
          tmr_value = TA_V;
        end
      end
      SHIFT1: tmr_load = tmr_expire;
      DONE: tmr_load = 1'b1;
      default: tmr_load = 1'b0;
    endcase
  end

  // Transaction sequencer; every pin and status output is a register here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cs_pin    <= 1'b1;
      sclk_pin  <= 1'b0;
      mosi_pin  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      rw_q      <= RW_WRITE;
      wdata_q   <= '0;
      shift_out <= '0;
      shift_in  <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rw_q      <= rw;
            wdata_q   <= wdata;
            shift_out <= {addr, rw};
            mosi_pin  <= addr[ADDR_W-1];
            shift_in  <= '0;
            bit_cnt   <= '0;
            cs_pin    <= 1'b0;
            sclk_pin  <= 1'b0;
            busy      <= 1'b1;
            state     <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (tmr_expire) state <= SHIFT0;
        end
        SHIFT0, SHIFT1: begin
          if (tmr_expire) begin
            if (!sclk_pin) begin
              sclk_pin <= 1'b1;
              if (state == SHIFT1 && rw_q == RW_READ) begin
                shift_in <= {shift_in[CMD_W-2:0], miso_pin};
              end
            end else begin
              sclk_pin  <= 1'b0;
              shift_out <= {shift_out[CMD_W-2:0], 1'b0};
              mosi_pin  <= shift_out[CMD_W-2];
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == SHIFT0) begin
                  state <= TURN;
                  if (rw_q == RW_READ) begin
                    shift_out <= '0;
                    mosi_pin  <= 1'b0;
                  end else begin
                    shift_out <= wdata_q;
                    mosi_pin  <= wdata_q[CMD_W-1];
                  end
                end else begin
                  state    <= CS_HOLD;
                  mosi_pin <= 1'b0;
                end
              end
            end
          end
        end
        TURN: begin
          if (tmr_expire) state <= SHIFT1;
        end
        CS_HOLD: begin
          if (tmr_expire) begin
            state  <= DONE;
            cs_pin <= 1'b1;
            done   <= 1'b1;
            if (rw_q == RW_READ) rdata <= shift_in;
          end
        end
        DONE: begin
          state <= CS_IDLE;
        end
        CS_IDLE: begin
          if (tmr_expire) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a behavioural SPI slave
module tb_spi_master;

  localparam int HP1 = 4;
  localparam int TA1 = 8;
  localparam int HP2 = 2;
  localparam int TA2 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sel   = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       miso  = 1'b0;

  logic start1, start2;
  assign start1 = start & ~sel;
  assign start2 = start & sel;

  logic [7:0] rdata1, rdata2;
  logic busy1, done1, sclk1, cs1, mosi1;
  logic busy2, done2, sclk2, cs2, mosi2;

  spi_master #(.HALF_PERIOD(HP1), .TURNAROUND(TA1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .busy(busy1), .done(done1), .sclk_pin(sclk1), .cs_pin(cs1),
    .mosi_pin(mosi1), .miso_pin(miso)
  );

  spi_master #(.HALF_PERIOD(HP2), .TURNAROUND(TA2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .busy(busy2), .done(done2), .sclk_pin(sclk2), .cs_pin(cs2),
    .mosi_pin(mosi2), .miso_pin(miso)
  );

  logic [7:0] rdata;
  logic busy, done, sclk, cs, mosi;
  assign rdata = sel ? rdata2 : rdata1;
  assign busy  = sel ? busy2  : busy1;
  assign done  = sel ? done2  : done1;
  assign sclk  = sel ? sclk2  : sclk1;
  assign cs    = sel ? cs2    : cs1;
  assign mosi  = sel ? mosi2  : mosi1;

  int hp, ta;
  always_comb begin
    hp = sel ? HP2 : HP1;
    ta = sel ? TA2 : TA1;
  end

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Slave model and phase monitor
  int         cyc = 0, nrise = 0, phase_err = 0, cs_falls = 0, t_last = 0, bit_n = 0;
  logic       sclk_prev = 1'b0, cs_prev = 1'b1;
  logic [15:0] mosi_sr = '0;
  logic [7:0]  miso_data = '0;

  always @(negedge clk) begin
    int len, expl;
    cyc++;
    if (cs_prev && !cs) begin
      nrise = 0;
      bit_n = 0;
      cs_falls++;
      miso = 1'b0;
    end
    cs_prev = cs;
    if (sclk !== sclk_prev) begin
      len = cyc - t_last;
      if (sclk) begin
        nrise++;
        mosi_sr = {mosi_sr[14:0], mosi};
        bit_n++;
        expl = (nrise == 9) ? hp + ta : hp;
        if (nrise >= 2 && len != expl) phase_err++;
      end else begin
        if (len != hp) phase_err++;
        if (bit_n >= 8 && bit_n < 16) miso = miso_data[15-bit_n];
      end
      t_last    = cyc;
      sclk_prev = sclk;
    end
  end

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] b1;
    logic [7:0] rdata;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso_d;
    logic [7:0] e_cmd;
    logic [7:0] e_b1;
    logic [7:0] e_rdata;
  } vec_t;
  vec_t vecs[5];

  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                         input logic [7:0] md, input logic [7:0] ec, input logic [7:0] eb,
                         input logic [7:0] er);
    exp_t e;
    int n, m, pe0, cf0;
    m = 0;
    while (busy && m < 500) begin @(posedge clk); #1; m++; end
    chk("idle_before_start", busy, 1'b0);
    miso_data = md;
    e.cmd = ec; e.b1 = eb; e.rdata = er; e.lat = 1 + 34*hp + ta;
    sb.push_back(e);
    @(posedge clk); #1;
    rw = r; addr = a; wdata = wd; start = 1'b1;
    pe0 = phase_err; cf0 = cs_falls;
    @(posedge clk); #1;
    start = 1'b0; addr = 7'($urandom); wdata = 8'($urandom); rw = ~r;
    chk("busy_after_accept", busy, 1'b1);
    n = 1;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("cmd_byte", mosi_sr[15:8], e.cmd);
    chk("data_byte", mosi_sr[7:0], e.b1);
    chk("rdata_at_done", rdata, e.rdata);
    chk("cs_high_at_done", cs, 1'b1);
    chk("sclk_phase_errors", phase_err - pe0, 0);
    chk("cs_fall_once", cs_falls - cf0, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    m = 1;
    while (busy && m < 500) begin @(posedge clk); #1; m++; end
    chk("busy_fall_after_done", m, hp + 1);
    chk("rdata_held", rdata, e.rdata);
  endtask

  initial begin
    int n, m, cf0, dseen;

    vecs[0] = '{1'b0, 7'h05, 8'hA5, 8'h00, 8'h0A, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 7'h05, 8'h77, 8'h3C, 8'h0B, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 7'h7F, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, 7'h2A, 8'hFF, 8'h81, 8'h55, 8'h00, 8'h81};
    vecs[4] = '{1'b0, 7'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h81};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_cs_dut2", cs2, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].miso_d,
              vecs[i].e_cmd, vecs[i].e_b1, vecs[i].e_rdata);
    end

    // start held high across the end of a transaction
    @(posedge clk); #1;
    rw = 1'b0; addr = 7'h12; wdata = 8'h34; start = 1'b1; cf0 = cs_falls;
    n = 0;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    chk("b2b_latency", n, 1 + 34*hp + ta);
    chk("b2b_single_accept", cs_falls - cf0, 1);
    m = 0;
    while (cs && m < 500) begin @(posedge clk); #1; m++; end
    chk("b2b_cs_high_min", (m >= hp), 1'b1);
    chk("b2b_cs_high_time", m, hp + 2);
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    chk("b2b_second_cmd", mosi_sr[15:8], 8'h24);
    chk("b2b_second_data", mosi_sr[7:0], 8'h34);

    // abort in the middle of byte 0
    m = 0;
    while (busy && m < 500) begin @(posedge clk); #1; m++; end
    miso_data = 8'hC3;
    @(posedge clk); #1;
    rw = 1'b1; addr = 7'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    m = 0;
    while (nrise < 3 && m < 1000) begin @(posedge clk); #1; m++; end
    while (sclk && m < 1000) begin @(posedge clk); #1; m++; end
    chk("abort_reached_bit3", nrise, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_cs", cs, 1'b1);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rdata", rdata, 8'h00);
    dseen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) dseen++; end
    chk("no_done_after_abort", dseen, 0);
    run_txn(1'b0, 7'h7F, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00);

    // minimum half period on the second instance
    sel = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 7'h00, 8'h5A, 8'hFF, 8'h01, 8'h00, 8'hFF);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
